// File: rtl/song_sequencer_if.sv
// Song-storage read port: one-cycle request with address, data returned with a valid strobe.
interface song_sequencer_if;
  logic       rd_req;
  logic [4:0] rd_addr;
  logic       rd_valid;
  logic [1:0] rd_data;

  modport master (output rd_req, rd_addr, input rd_valid, rd_data);
  modport slave  (input rd_req, rd_addr, output rd_valid, rd_data);
endinterface

// File: rtl/song_sequencer.sv
// GuitarVillains playback controller: fetches one note per beat, keeps a 4-note history.
// Define SONG_LOOP_EN to wrap to position 0 after the last beat instead of stopping in DONE.
module song_sequencer #(
  parameter int unsigned SONG_LEN   = 32,
  parameter int unsigned TICK_DIV   = 10000000,
  parameter int unsigned RD_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [2:0]              mode,
  input  logic                    start,
  input  logic                    pause,
  song_sequencer_if.master        mem,
  output logic [1:0]              cur_note,
  output logic                    cur_valid,
  output logic [7:0]              note_hist,
  output logic [4:0]              position,
  output logic                    busy,
  output logic                    song_done,
  output logic                    rd_err
);

  localparam int unsigned BW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT + 1) : 1;
  localparam logic [2:0]    PLAY      = 3'd3;
  localparam logic [4:0]    LAST_POS  = 5'(SONG_LEN - 1);
  localparam logic [BW-1:0] TICK_LAST = BW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_RD, HOLD, DONE} state_t;

  state_t        state, state_n;
  logic [BW-1:0] beat, beat_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [4:0]    pos_n, addr_n;
  logic [1:0]    note_n, note_in;
  logic [7:0]    hist_n;
  logic          req_n, cv_n, err_n, busy_n, done_n;
`ifdef SONG_LOOP_EN
  logic          wrap;
`endif

  always_comb begin
    state_n = state;
    beat_n  = beat;
    tmo_n   = tmo;
    pos_n   = position;
    addr_n  = mem.rd_addr;
    req_n   = 1'b0;
    note_n  = cur_note;
    note_in = 2'b00;
    cv_n    = 1'b0;
    hist_n  = note_hist;
    err_n   = rd_err;
`ifdef SONG_LOOP_EN
    wrap    = 1'b0;
`endif

    case (state)
      IDLE, DONE: begin
        if (start && mode == PLAY) begin
          state_n = FETCH;
          pos_n   = '0;
          addr_n  = '0;
          req_n   = 1'b1;
          hist_n  = '0;
          err_n   = 1'b0;
          beat_n  = '0;
          tmo_n   = '0;
        end
      end
      FETCH: begin
        state_n = WAIT_RD;
        tmo_n   = '0;
      end
      WAIT_RD: begin
        // A timeout finishes the beat exactly like a read, but with a rest note.
        if (mem.rd_valid || tmo == TO_LAST) begin
          if (mem.rd_valid) note_in = mem.rd_data;
          else              err_n   = 1'b1;
          note_n  = note_in;
          hist_n  = {note_hist[5:0], note_in};
          cv_n    = 1'b1;
          beat_n  = '0;
          state_n = HOLD;
        end else begin
          tmo_n = tmo + TW'(1);
        end
      end
      HOLD: begin
        if (!pause) begin
          if (beat == TICK_LAST) begin
            if (position != LAST_POS) begin
              pos_n   = position + 5'd1;
              addr_n  = position + 5'd1;
              req_n   = 1'b1;
              state_n = FETCH;
            end else begin
`ifdef SONG_LOOP_EN
              pos_n   = '0;
              addr_n  = '0;
              req_n   = 1'b1;
              wrap    = 1'b1;
              state_n = FETCH;
`else
              state_n = DONE;
`endif
            end
          end else begin
            beat_n = beat + BW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Leaving PLAY overrides every transition computed above.
    if (state != IDLE && mode != PLAY) begin
      state_n = IDLE;
      pos_n   = '0;
      addr_n  = '0;
      req_n   = 1'b0;
      note_n  = '0;
      cv_n    = 1'b0;
      hist_n  = '0;
      beat_n  = '0;
      tmo_n   = '0;
`ifdef SONG_LOOP_EN
      wrap    = 1'b0;
`endif
    end

    busy_n = (state_n == FETCH) || (state_n == WAIT_RD) || (state_n == HOLD);
`ifdef SONG_LOOP_EN
    done_n = wrap;
`else
    done_n = (state_n == DONE);
`endif
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      beat        <= '0;
      tmo         <= '0;
      position    <= '0;
      mem.rd_addr <= '0;
      mem.rd_req  <= 1'b0;
      cur_note    <= '0;
      cur_valid   <= 1'b0;
      note_hist   <= '0;
      rd_err      <= 1'b0;
      busy        <= 1'b0;
      song_done   <= 1'b0;
    end else begin
      state       <= state_n;
      beat        <= beat_n;
      tmo         <= tmo_n;
      position    <= pos_n;
      mem.rd_addr <= addr_n;
      mem.rd_req  <= req_n;
      cur_note    <= note_n;
      cur_valid   <= cv_n;
      note_hist   <= hist_n;
      rd_err      <= err_n;
      busy        <= busy_n;
      song_done   <= done_n;
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboarded bench for song_sequencer with a 4-entry song and a one-idle-cycle storage model.
module tb_song_sequencer;
  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [2:0] mode = 3'd0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] cur_note;
  logic       cur_valid;
  logic [7:0] note_hist;
  logic [4:0] position;
  logic       busy, song_done, rd_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_addr[$];
  int exp_note[$];
  int req_cyc[$];
  int val_cyc[$];
  int withhold = -1;
  int done_hi = 0;
  logic done_busy = 1'b0;
  logic [1:0] rom [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

  song_sequencer_if mem ();

  song_sequencer #(.SONG_LEN(4), .TICK_DIV(4), .RD_TIMEOUT(3)) dut (
    .clk(clk), .nrst(nrst), .mode(mode), .start(start), .pause(pause), .mem(mem),
    .cur_note(cur_note), .cur_valid(cur_valid), .note_hist(note_hist), .position(position),
    .busy(busy), .song_done(song_done), .rd_err(rd_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_vals(input int n, input string name);
    int k = 0;
    while (val_cyc.size() < n && k < 300) begin tick(); k++; end
    chk(name, 32'(val_cyc.size() >= n), 1);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (!song_done && k < 300) begin tick(); k++; end
    chk(name, 32'(song_done), 1);
  endtask

  task automatic new_run(input int n_addr, input int notes[$]);
    req_cyc.delete();
    val_cyc.delete();
    for (int i = 0; i < n_addr; i++) exp_addr.push_back(i);
    foreach (notes[i]) exp_note.push_back(notes[i]);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_position"}, position, 0);
    chk({tag, "_note_hist"}, note_hist, 0);
    chk({tag, "_cur_note"}, cur_note, 0);
    chk({tag, "_rd_req"}, mem.rd_req, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_song_done"}, song_done, 0);
  endtask

  // Storage model: request seen in cycle c, data valid for one cycle in c+2.
  initial begin
    int a;
    mem.rd_valid = 1'b0;
    mem.rd_data  = 2'b00;
    forever begin
      @(negedge clk);
      if (mem.rd_req) begin
        a = int'(mem.rd_addr);
        @(negedge clk);
        @(negedge clk);
        if (a != withhold) begin
          mem.rd_valid = 1'b1;
          mem.rd_data  = rom[a[1:0]];
        end
        @(negedge clk);
        mem.rd_valid = 1'b0;
      end
    end
  end

  // Monitor: pops expected address/note whenever the DUT presents a request or a beat.
  initial begin
    forever begin
      @(negedge clk);
      if (mem.rd_req) begin
        req_cyc.push_back(cyc);
        if (exp_addr.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rd_req: got addr %0d, required no request", mem.rd_addr);
        end else chk("rd_addr", mem.rd_addr, exp_addr.pop_front());
      end
      if (cur_valid) begin
        val_cyc.push_back(cyc);
        if (exp_note.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_cur_valid: got note %0d, required no beat", cur_note);
        end else chk("cur_note", cur_note, exp_note.pop_front());
      end
      if (song_done) begin
        done_hi++;
        done_busy = busy;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk_idle_outputs("reset");
    chk("reset_cur_valid", cur_valid, 0);
    chk("reset_rd_err", rd_err, 0);
    chk("reset_rd_addr", mem.rd_addr, 0);
    nrst = 1'b1;
    tick();
    mode = 3'd3;

`ifdef SONG_LOOP_EN
    new_run(4, '{1, 2, 3, 0, 1});
    exp_addr.push_back(0);
    pulse_start();
    wait_vals(5, "loop_beats");
    chk("loop_done_cycles", done_hi, 1);
    chk("loop_busy_at_done", done_busy, 1);
    chk("loop_busy", busy, 1);
    chk("loop_wrap_spacing", req_cyc[4] - req_cyc[3], 7);
    mode = 3'd2;
    tick();
    chk_idle_outputs("loop_abort");
`else
    // Normal play with an ignored start while busy.
    new_run(4, '{1, 2, 3, 0});
    pulse_start();
    wait_vals(1, "normal_first_beat");
    pulse_start();
    wait_done("normal_done");
    chk("normal_hist", note_hist, 8'b01_10_11_00);
    chk("normal_busy", busy, 0);
    chk("normal_position", position, 3);
    chk("normal_rd_err", rd_err, 0);
    chk("normal_latency", val_cyc[0] - req_cyc[0], 3);
    for (int i = 1; i < 4; i++) chk("normal_spacing", val_cyc[i] - val_cyc[i-1], 7);
    chk("normal_req_count", req_cyc.size(), 4);

    // Timeout at address 2, replay started from DONE.
    withhold = 2;
    new_run(4, '{1, 2, 0, 0});
    pulse_start();
    wait_done("timeout_done");
    withhold = -1;
    chk("timeout_rd_err", rd_err, 1);
    chk("timeout_hist", note_hist, 8'b01_10_00_00);
    chk("timeout_wait_cycles", val_cyc[2] - req_cyc[2], 4);
    chk("timeout_normal_latency", val_cyc[1] - req_cyc[1], 3);

    // Pause for 5 cycles in HOLD of position 1; start clears rd_err.
    new_run(4, '{1, 2, 3, 0});
    pulse_start();
    chk("start_clears_rd_err", rd_err, 0);
    wait_vals(2, "pause_second_beat");
    pause = 1'b1;
    repeat (5) tick();
    pause = 1'b0;
    wait_done("pause_done");
    chk("pause_req01", req_cyc[1] - req_cyc[0], 7);
    chk("pause_req12", req_cyc[2] - req_cyc[1], 12);
    chk("pause_req23", req_cyc[3] - req_cyc[2], 7);

    // Abort during WAIT_RD; the pending read's rd_valid must be ignored.
    new_run(1, '{});
    pulse_start();
    wait_vals(0, "abort_rd_sync");
    while (req_cyc.size() < 1) tick();
    tick();
    mode = 3'd2;
    tick();
    chk_idle_outputs("abort_wait");
    mode = 3'd3;
    repeat (4) tick();
    chk("abort_no_beat", val_cyc.size(), 0);
    chk("abort_stays_idle", busy, 0);

    // Abort during HOLD of position 1 clears note state.
    new_run(2, '{1, 2});
    pulse_start();
    wait_vals(2, "abort_hold_beats");
    chk("abort_hold_pre_position", position, 1);
    chk("abort_hold_pre_hist", note_hist, 8'b0000_0110);
    mode = 3'd2;
    tick();
    chk_idle_outputs("abort_hold");
    mode = 3'd3;

    // Asynchronous reset mid-HOLD.
    new_run(1, '{1});
    pulse_start();
    wait_vals(1, "reset_run_beat");
    tick();
    #1 nrst = 1'b0;
    #1;
    chk_idle_outputs("async_reset");
    chk("async_reset_cur_valid", cur_valid, 0);
    tick();
    nrst = 1'b1;
    repeat (3) tick();
`endif

    chk("addr_queue_empty", exp_addr.size(), 0);
    chk("note_queue_empty", exp_note.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Playback controller for the GuitarVillains song datapath.
- In play mode it walks the stored song position by position at a fixed tempo. For each position it fetches the 2-bit note from song storage over a request/valid handshake, presents it as the current note with a one-cycle beat strobe, and keeps a 4-deep note history for the lane display.
- Drives the position seven-segment path and signals end of song to the game/score logic.

Parameters:
- SONG_LEN, 32, number of song positions; position counts 0..SONG_LEN-1; max 32.
- TICK_DIV, 10000000, clk cycles per beat hold, counted in HOLD only; min 2.
- RD_TIMEOUT, 15, max cycles waited for rd_valid before substituting a rest note.

Ports:
- clk  in  1  system clock.
- nrst  in  1  asynchronous active-low reset.
- mode  in  3  game mode; 3'd3 = PLAY; any other value aborts playback.
- start  in  1  single-cycle pulse; begins playback from position 0.
- pause  in  1  level; freezes beat counter while high.
- rd_req  out  1  one-cycle read request to song storage.
- rd_addr  out  5  read address, equal to position while rd_req is high.
- rd_valid  in  1  read data valid.
- rd_data  in  2  note from storage.
- cur_note  out  2  note of current beat.
- cur_valid  out  1  one-cycle strobe when cur_note updates.
- note_hist  out  8  last 4 notes, newest in [1:0], oldest in [7:6].
- position  out  5  current song position.
- busy  out  1  high in FETCH, WAIT_RD, HOLD.
- song_done  out  1  high in DONE.
- rd_err  out  1  sticky; set on read timeout; cleared on start or reset.

Behaviour:
- Clock/reset: one clock (clk). Reset is asynchronous and active-low (nrst).
- Reset values: all outputs 0; state IDLE; beat and timeout counters 0.
- All outputs are registered.
- State IDLE: start=1 && mode==3 -> FETCH; position=0; note_hist=0; rd_err=0.
- State FETCH, one cycle:
  - rd_req=1, rd_addr=position.
  - -> WAIT_RD, timeout counter cleared.
- State WAIT_RD:
  - rd_valid is sampled only in this state; earliest accepted is the cycle after rd_req.
  - rd_valid=1: cur_note<=rd_data; note_hist<={note_hist[5:0],rd_data}; cur_valid=1 for one cycle; beat counter=0; -> HOLD.
  - Timeout counter reaches RD_TIMEOUT with no rd_valid: same as above, with note 2'b00, and rd_err<=1.
- State HOLD:
  - Beat counter increments each cycle while pause=0; holds while pause=1.
  - Counter==TICK_DIV-1, position<SONG_LEN-1: position++ -> FETCH.
  - Counter==TICK_DIV-1, position==SONG_LEN-1: -> DONE.
- State DONE:
  - song_done=1, busy=0; cur_note and note_hist hold.
  - start=1 && mode==3 -> FETCH, same initialisation as from IDLE.
- Abort: mode!=3 in any non-IDLE state -> IDLE next cycle.
  - position, cur_note, note_hist, counters cleared; rd_req deasserted.
  - Abort has priority over every other transition.
- start while busy=1: ignored.
- pause: ignored outside HOLD. Fetch and timeout logic are never frozen.
- Timing:
  - start sampled at edge N -> rd_req high in cycle N+1.
  - Beat period = 2 + read latency + TICK_DIV cycles (no pause).
- position width: 5 bits; never exceeds SONG_LEN-1.
- Reset mid-read: any late rd_valid after reset/abort is ignored, because rd_valid is not sampled in IDLE.

Optional Feature:
- Macro SONG_LOOP_EN.
- Defined: at end of last beat, position wraps to 0 and state -> FETCH instead of DONE. song_done pulses high for exactly one cycle per wrap; the DONE state is unreachable. Playback continues until mode!=3.
- Undefined: behaviour exactly as above; song_done is a level in DONE.

Test Plan:
Bench parameters for all scenarios: SONG_LEN=4, TICK_DIV=4, RD_TIMEOUT=3; memory returns rd_valid 1 cycle after rd_req, with notes {1,2,3,0} at addresses 0..3.
- Normal play: mode=3, start pulse -> rd_addr 0,1,2,3 in order; cur_valid pulses show cur_note 1,2,3,0; note_hist ends at 8'b01_10_11_00; beat-to-beat spacing 7 cycles; song_done=1, busy=0.
- Pause: assert pause 5 cycles during HOLD of position 1 -> next rd_req delayed exactly 5 cycles; note sequence unchanged.
- Timeout: memory withholds rd_valid at address 2 -> after 3 WAIT_RD cycles, cur_note=0, cur_valid pulses, rd_err=1 sticky; playback continues to DONE; next start clears rd_err.
- Abort and reset: mode->3'd2 during WAIT_RD -> IDLE next cycle; position=0, note_hist=0, rd_req=0; late rd_valid ignored. nrst low mid-HOLD -> all outputs 0 immediately.
- Start handling: start pulse while busy -> no effect, position sequence unchanged. start in DONE -> replay from rd_addr 0. With SONG_LOOP_EN: after address 3, rd_addr 0 follows, song_done is high exactly 1 cycle, and busy stays 1.
